maze_game_ctrl: RTL
===================

// Module: maze_game_ctrl
// PURPOSE
//   Game sequencer for the maze levels. Selects which level graphic drives the screen.
//   Samples the selected level's path (graph_on) and goal (finalbox) flags at the cursor pixel.
//   Once per frame it advances the level, triggers the scare screen or declares a win.
//   Sits between the per-level graphic generators / VGA sync and the RGB output register.
// PARAMETERS
//   NUM_LEVELS    3    number of level graphic generators attached (1..4)
//   MISS_FRAMES   2    consecutive off-path frames that trigger SCARE (1..15)
//   SCARE_FRAMES  120  frames the scare screen is held (1..255)
//   V_ACTIVE      480  first non-visible line; frame tick at pix_y==V_ACTIVE, pix_x==0
//   CURSOR_HALF   2    cursor square half-size in pixels
// PORTS
//   clk           in   1             system clock
//   reset         in   1             asynchronous, active-low reset
//   p_tick        in   1             pixel-enable strobe from VGA sync
//   video_on      in   1             visible-area flag
//   pix_x, pix_y  in   10 each       current pixel coordinate
//   cursor_x/_y   in   10 each       player cursor position, stable within a frame
//   start         in   1             one-clk start pulse (debounced button)
//   lvl_graph_on  in   NUM_LEVELS    path flag per level, bit i = level i
//   lvl_finalbox  in   NUM_LEVELS    goal-box flag per level
//   lvl_rgb       in   3*NUM_LEVELS  rgb per level, [3i+2:3i] = level i
//   level         out  2             current level index
//   state_o       out  2             00 IDLE, 01 PLAY, 10 SCARE, 11 WIN
//   rgb_out       out  3             final pixel colour
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE, level 0, miss_cnt 0, scare_cnt 0,
//     hit flags 0, flash 0. rgb_out=000, level=0, state_o=00.
//   All registers update only on clk edges with p_tick=1, except start, which is sampled every clk.
//   frame_tick = p_tick & pix_y==V_ACTIVE & pix_x==0 (one p_tick per frame).
//   Cursor sample: on p_tick & video_on & pix_x==cursor_x & pix_y==cursor_y, latch
//     on_path=lvl_graph_on[level] and at_goal=lvl_finalbox[level].
//     Latched flags clear on the frame_tick that evaluates them.
//     No sample in a frame (cursor off-screen) -> on_path=0, at_goal=0.
//   FSM, evaluated on frame_tick unless noted:
//     IDLE:  start -> PLAY, level 0, miss_cnt 0 (any clk).
//     PLAY:  at_goal -> level+1, miss_cnt 0; if level==NUM_LEVELS-1 -> WIN instead.
//            else !on_path -> miss_cnt+1; on reaching MISS_FRAMES -> SCARE, scare_cnt 0.
//            else -> miss_cnt 0.
//            at_goal has priority over off-path in the same frame.
//     SCARE: scare_cnt+1 and flash toggles each frame.
//            At scare_cnt==SCARE_FRAMES-1 -> IDLE, level 0.
//     WIN:   start -> IDLE, level 0. A start pulse in PLAY or SCARE is ignored.
//   miss_cnt saturates (4 bits); scare_cnt is 8 bits; level never exceeds NUM_LEVELS-1.
//   rgb_out, combinational from registered state (zero pixel latency):
//     !video_on -> 000.
//     PLAY: cursor square (|pix-cursor|<=CURSOR_HALF) -> 100, else lvl_rgb[level].
//     SCARE: flash ? 111 : 100.   WIN: 010.   IDLE: 000.
//   Reset asserted mid-game returns immediately to the reset values above.
// TESTING
//   1 Reset low mid-PLAY at level 1 -> state_o=00, level=0, rgb_out=000 without a clk edge.
//   2 IDLE, start pulse, cursor on path for 5 frames -> state_o=01, level=0, miss_cnt stays 0.
//   3 PLAY level 0, cursor off path for 1 frame then back -> no SCARE.
//     Off path for 2 frames -> state_o=10 at the 2nd frame_tick.
//     Returns to IDLE exactly 120 frame_ticks later.
//   4 PLAY, cursor in finalbox: level 0->1->2 on successive frames.
//     Goal on level 2 -> state_o=11, rgb_out=010; start -> IDLE, level 0.
//   5 Goal and off-path flags in the same frame (at_goal=1, on_path=0) -> level advances, no SCARE.
//   6 Cursor at x=700 (never sampled) in PLAY -> counted as off path; SCARE after 2 frames.
//     start pulse during SCARE is ignored.

Source files
------------

// File: rtl/maze_game_ctrl_if.sv
// Video-side bundle between VGA sync / level generators and the maze game sequencer.
// The master drives pixel timing and per-level graphics; the slave returns the final pixel colour.
interface maze_game_ctrl_if #(
    parameter int unsigned NUM_LEVELS = 3
) ();
    logic                      p_tick;
    logic                      video_on;
    logic [9:0]                pix_x;
    logic [9:0]                pix_y;
    logic [NUM_LEVELS-1:0]     lvl_graph_on;
    logic [NUM_LEVELS-1:0]     lvl_finalbox;
    logic [3*NUM_LEVELS-1:0]   lvl_rgb;
    logic [2:0]                rgb_out;

    modport master (
        output p_tick, video_on, pix_x, pix_y, lvl_graph_on, lvl_finalbox, lvl_rgb,
        input  rgb_out
    );

    modport slave (
        input  p_tick, video_on, pix_x, pix_y, lvl_graph_on, lvl_finalbox, lvl_rgb,
        output rgb_out
    );
endinterface

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: samples the active level's path/goal flags at the cursor pixel,
// steps level / scare / win once per frame and muxes the output pixel colour.
module maze_game_ctrl #(
    parameter int unsigned NUM_LEVELS   = 3,
    parameter int unsigned MISS_FRAMES  = 2,
    parameter int unsigned SCARE_FRAMES = 120,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned CURSOR_HALF  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [9:0]     cursor_x,
    input  logic [9:0]     cursor_y,
    output logic [1:0]     level,
    output logic [1:0]     state_o,
    maze_game_ctrl_if.slave vid
);
    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StPlay  = 2'b01;
    localparam logic [1:0] StScare = 2'b10;
    localparam logic [1:0] StWin   = 2'b11;

    localparam logic [9:0] VActive    = 10'(V_ACTIVE);
    localparam logic [1:0] LastLevel  = 2'(NUM_LEVELS - 1);
    localparam logic [3:0] MissFrames = 4'(MISS_FRAMES);
    localparam logic [7:0] ScareLast  = 8'(SCARE_FRAMES - 1);
    localparam logic [9:0] CursorHalf = 10'(CURSOR_HALF);

    logic [1:0] state_q, state_d;
    logic [1:0] level_q, level_d;
    logic [3:0] miss_q, miss_d;
    logic [7:0] scare_q, scare_d;
    logic       flash_q, flash_d;
    logic       on_path_q, on_path_d;
    logic       at_goal_q, at_goal_d;

    logic       frame_tick, sample;
    logic       cur_on, cur_goal;
    logic [2:0] cur_rgb;
    logic [3:0] miss_inc;
    logic [9:0] dx, dy;

    assign frame_tick = vid.p_tick && (vid.pix_y == VActive) && (vid.pix_x == 10'd0);
    assign sample     = vid.p_tick && vid.video_on &&
                        (vid.pix_x == cursor_x) && (vid.pix_y == cursor_y);
    assign miss_inc   = (miss_q == 4'hf) ? miss_q : miss_q + 4'd1;

    // Select the current level's flags and colour without a variable-width part select.
    always_comb begin
        cur_on   = 1'b0;
        cur_goal = 1'b0;
        cur_rgb  = 3'b000;
        for (int i = 0; i < int'(NUM_LEVELS); i++) begin
            if (level_q == 2'(i)) begin
                cur_on   = vid.lvl_graph_on[i];
                cur_goal = vid.lvl_finalbox[i];
                cur_rgb  = vid.lvl_rgb[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        miss_d    = miss_q;
        scare_d   = scare_q;
        flash_d   = flash_q;
        on_path_d = on_path_q;
        at_goal_d = at_goal_q;

        if (sample) begin
            on_path_d = cur_on;
            at_goal_d = cur_goal;
        end
        if (frame_tick) begin
            on_path_d = 1'b0;
            at_goal_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPlay;
                    level_d = 2'd0;
                    miss_d  = 4'd0;
                end
            end
            StPlay: begin
                if (frame_tick) begin
                    if (at_goal_q) begin
                        miss_d = 4'd0;
                        if (level_q == LastLevel) begin
                            state_d = StWin;
                        end else begin
                            level_d = level_q + 2'd1;
                        end
                    end else if (!on_path_q) begin
                        miss_d = miss_inc;
                        if (miss_inc >= MissFrames) begin
                            state_d = StScare;
                            scare_d = 8'd0;
                        end
                    end else begin
                        miss_d = 4'd0;
                    end
                end
            end
            StScare: begin
                if (frame_tick) begin
                    scare_d = scare_q + 8'd1;
                    flash_d = ~flash_q;
                    if (scare_q == ScareLast) begin
                        state_d = StIdle;
                        level_d = 2'd0;
                    end
                end
            end
            StWin: begin
                if (start) begin
                    state_d = StIdle;
                    level_d = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            level_q   <= 2'd0;
            miss_q    <= 4'd0;
            scare_q   <= 8'd0;
            flash_q   <= 1'b0;
            on_path_q <= 1'b0;
            at_goal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            miss_q    <= miss_d;
            scare_q   <= scare_d;
            flash_q   <= flash_d;
            on_path_q <= on_path_d;
            at_goal_q <= at_goal_d;
        end
    end

    assign dx = (vid.pix_x >= cursor_x) ? vid.pix_x - cursor_x : cursor_x - vid.pix_x;
    assign dy = (vid.pix_y >= cursor_y) ? vid.pix_y - cursor_y : cursor_y - vid.pix_y;

    always_comb begin
        vid.rgb_out = 3'b000;
        if (vid.video_on) begin
            unique case (state_q)
                StPlay:  vid.rgb_out = (dx <= CursorHalf && dy <= CursorHalf) ? 3'b100 : cur_rgb;
                StScare: vid.rgb_out = flash_q ? 3'b111 : 3'b100;
                StWin:   vid.rgb_out = 3'b010;
                StIdle:  vid.rgb_out = 3'b000;
            endcase
        end
    end

    assign level   = level_q;
    assign state_o = state_q;
endmodule
